regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and initialisation sequencer in front of the integer register file's write ports. Shares NR_WRITE_PORTS register-file write ports among NR_WB functional-unit write-back requesters using round-robin priority and a valid/ready handshake. After reset it zeroes registers x1..x31 through write port 0 before accepting any request. All outputs toward the register file are registered.

## Interface
- NR_WB, 4: number of write-back requesters (2..8)
- NR_WRITE_PORTS, 2: register-file write ports driven (1..NR_WB)
- DATA_WIDTH, 64: register width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- wb_valid_i  in  NR_WB  requester i has a write pending
- wb_ready_o  out  NR_WB  requester i accepted this cycle (combinational)
- wb_waddr_i  in  NR_WB x 5  destination register per requester
- wb_wdata_i  in  NR_WB x DATA_WIDTH  write data per requester
- waddr_o  out  NR_WRITE_PORTS x 5  register-file write address
- wdata_o  out  NR_WRITE_PORTS x DATA_WIDTH  register-file write data
- we_o  out  NR_WRITE_PORTS  register-file write enable
- init_done_o  out  1  init sequence complete, arbitration enabled

## Operation
- States: INIT, RUN. Reset state INIT; INIT -> RUN after the last init write; RUN is held until reset.
- INIT: counter cnt resets to 1. Each cycle, port 0 output registers load waddr=cnt, wdata=0, we=1; cnt increments. The cycle that loads cnt=31 moves the state to RUN and sets init_done_o. Ports 1..NR_WRITE_PORTS-1 have we=0 throughout. All wb_ready_o are 0.
- RUN, per cycle:
  - Scan requesters in order rr_q, rr_q+1, ... (mod NR_WB).
  - A valid requester with waddr=0 gets ready=1. It consumes no port and generates no write.
  - A valid requester with waddr!=0 gets ready=1 and the next free port (lowest index first) if:
    - a port remains free, and
    - no requester already granted this cycle targets the same waddr.
  - Colliding or port-less requesters get ready=0 and must retry.
- Handshake: a transfer occurs when valid=1 and ready=1. The requester holds valid, waddr and wdata stable until it is accepted. ready never depends on anything except state, rr_q, wb_valid_i and wb_waddr_i.
- Granted port p loads waddr_o[p], wdata_o[p] and we_o[p]=1 on the next edge. Ports not granted load we_o=0; their waddr_o and wdata_o hold their previous values.
- Round-robin: if at least one port-consuming grant occurred, rr_q <= (index of last port-consuming grantee + 1) mod NR_WB. Otherwise rr_q is unchanged. Reset value of rr_q is 0.
- Result: no two ports ever write the same address in one cycle, and x0 is never written.

## Timing
- Reset values: we_o=0, waddr_o=0, wdata_o=0, init_done_o=0, wb_ready_o=0, state=INIT, cnt=1, rr_q=0.
- Init sequence:
  - First edge after rst_ni deasserts: we_o[0]=1, waddr_o[0]=1.
  - 31 consecutive cycles present addresses 1..31.
  - init_done_o rises on the same edge that presents address 31.
  - First acceptance is possible in that cycle.
- RUN latency: handshake in cycle N appears on we_o/waddr_o/wdata_o in cycle N+1. Throughput is NR_WRITE_PORTS writes per cycle.
- Reset asserted mid-INIT or mid-RUN: all state returns to reset values immediately. Init restarts from address 1 after deassertion. A handshake in the cycle reset asserts is lost.
- A requester that stays valid is granted within ceil(NR_WB / NR_WRITE_PORTS) + 1 cycles, provided no persistent same-address collision occurs.

## Test plan
- Reset release, no requests -> we_o[0]=1 for exactly 31 cycles with addresses 1..31 in order and data 0; we_o[1]=0; init_done_o=1 from the cycle showing address 31; wb_ready_o=0 before that cycle.
- RUN, requesters 0 and 1 valid (x5=0xAA, x6=0xBB), rr_q=0 -> both ready same cycle; next cycle port0 writes x5=0xAA and port1 writes x6=0xBB; rr_q=2.
- RUN, all 4 requesters valid continuously, distinct addresses, rr_q=0 -> cycle 1 grants {0,1}, cycle 2 grants {2,3}, cycle 3 grants {0,1}.
- RUN, requesters 0 and 1 both target x7 (data 1 and 2), rr_q=0 -> cycle 1: req0 granted, req1 ready=0; cycle 2: req1 granted; we_o shows x7=1 and then x7=2 on consecutive cycles, never two ports on x7 together.
- RUN, requester 2 targets x0 and requesters 0 and 1 target x3 and x4 -> all three ready in one cycle; only x3 and x4 are written; no we_o with waddr 0.
- Reset pulsed at init cycle 10 -> outputs clear immediately; after release the sequence restarts at address 1 and runs the full 31 cycles.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus between functional units and the register-file arbiter,
// together with the registered register-file write-port outputs.
interface regfile_wb_arbiter_if #(
   parameter int NR_WB          = 4,
   parameter int NR_WRITE_PORTS = 2,
   parameter int DATA_WIDTH     = 64
);
   logic [NR_WB-1:0]                           wb_valid_i;
   logic [NR_WB-1:0]                           wb_ready_o;
   logic [NR_WB-1:0][4:0]                      wb_waddr_i;
   logic [NR_WB-1:0][DATA_WIDTH-1:0]           wb_wdata_i;
   logic [NR_WRITE_PORTS-1:0][4:0]             waddr_o;
   logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_o;
   logic [NR_WRITE_PORTS-1:0]                  we_o;

   modport master (
      output wb_valid_i, wb_waddr_i, wb_wdata_i,
      input  wb_ready_o, waddr_o, wdata_o, we_o
   );

   modport slave (
      input  wb_valid_i, wb_waddr_i, wb_wdata_i,
      output wb_ready_o, waddr_o, wdata_o, we_o
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write ports among write-back
// requesters; after reset it first zeroes x1..x31 through write port 0.
module regfile_wb_arbiter #(
   parameter int NR_WB          = 4,
   parameter int NR_WRITE_PORTS = 2,
   parameter int DATA_WIDTH     = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   regfile_wb_arbiter_if.slave  bus,
   output logic                 init_done_o
);

   localparam int RRW = (NR_WB > 1) ? $clog2(NR_WB) : 1;

   typedef enum logic {INIT, RUN} state_e;

   state_e                                     state_q, state_d;
   logic [4:0]                                 cnt_q, cnt_d;
   logic [RRW-1:0]                             rr_q, rr_d;
   logic [NR_WRITE_PORTS-1:0][4:0]             waddr_q, waddr_d;
   logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [NR_WRITE_PORTS-1:0]                  we_q, we_d;
   logic                                       init_done_q, init_done_d;
   logic [NR_WB-1:0]                           ready;
   logic [RRW:0]                               scan_sum;
   logic [RRW-1:0]                             scan_idx;
   logic                                       collide;
   logic                                       placed;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= INIT;
         cnt_q       <= 5'd1;
         rr_q        <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         we_q        <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         init_done_q <= init_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'd31) state_d = RUN;
      end
   end

   // Ports fill lowest-first in scan order; a later requester aiming at an
   // address already granted this cycle must wait so no two ports collide.
   always_comb begin
      ready       = '0;
      we_d        = '0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      rr_d        = rr_q;
      init_done_d = init_done_q;
      scan_sum    = '0;
      scan_idx    = '0;
      collide     = 1'b0;
      placed      = 1'b0;
      if (state_q == INIT) begin
         we_d[0]     = 1'b1;
         waddr_d[0]  = cnt_q;
         wdata_d[0]  = '0;
         init_done_d = (cnt_q == 5'd31);
      end else begin
         init_done_d = 1'b1;
         for (int k = 0; k < NR_WB; k++) begin
            scan_sum = {1'b0, rr_q} + (RRW+1)'(k);
            if (scan_sum >= (RRW+1)'(NR_WB)) scan_sum = scan_sum - (RRW+1)'(NR_WB);
            scan_idx = scan_sum[RRW-1:0];
            collide  = 1'b0;
            placed   = 1'b0;
            if (bus.wb_valid_i[scan_idx]) begin
               if (bus.wb_waddr_i[scan_idx] == 5'd0) begin
                  ready[scan_idx] = 1'b1;
               end else begin
                  for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                     if (we_d[p] && (waddr_d[p] == bus.wb_waddr_i[scan_idx])) collide = 1'b1;
                  end
                  if (!collide) begin
                     for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                        if (!placed && !we_d[p]) begin
                           we_d[p]    = 1'b1;
                           waddr_d[p] = bus.wb_waddr_i[scan_idx];
                           wdata_d[p] = bus.wb_wdata_i[scan_idx];
                           placed     = 1'b1;
                        end
                     end
                  end
                  if (placed) begin
                     ready[scan_idx] = 1'b1;
                     rr_d = (scan_idx == RRW'(NR_WB-1)) ? '0 : scan_idx + RRW'(1);
                  end
               end
            end
         end
      end
   end

   assign bus.wb_ready_o = ready;
   assign bus.waddr_o    = waddr_q;
   assign bus.wdata_o    = wdata_q;
   assign bus.we_o       = we_q;
   assign init_done_o    = init_done_q;

endmodule
